// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_WIDTH = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler, shared by the length header and the
// data words. The first byte of each group lands in bits [7:0].
module byte_packer
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [BYTE_CNT_WIDTH-1:0] byte_cnt;
  logic [31:0]               word_q;

  // Present the word with the incoming byte already inserted, so the consumer
  // can capture the complete word on the same edge that takes the last byte.
  always_comb begin
    o_word = word_q;
    o_word[{byte_cnt, 3'b000} +: 8] = i_byte;
    o_word_valid = i_accept && (byte_cnt == BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1));
  end

  // Byte counter wraps naturally after the fourth byte; clear restarts a group.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (i_clear) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (i_accept) begin
      byte_cnt <= byte_cnt + BYTE_CNT_WIDTH'(1);
      word_q   <= o_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: takes a length-prefixed little-endian byte image
// and writes it word by word into the instruction RAM, holding the core in
// reset while the load is in progress.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rx_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int          MEM_DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [31:0] MEM_DEPTH_32 = 32'(MEM_DEPTH);

  loader_state_e         state;
  loader_state_e         next_state;
  logic [31:0]           len;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [31:0]           packed_word;
  logic                  word_valid;
  logic                  accept;
  logic                  start_ok;
  logic                  last_word;

  assign accept    = i_rx_valid & o_rx_ready;
  assign start_ok  = i_start & ((state == IDLE) | (state == DONE) | (state == ERR));
  assign last_word = ((32'(word_cnt) + 32'd1) == len);

  byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (start_ok),
    .i_accept     (accept),
    .i_byte       (i_rx_data),
    .o_word       (packed_word),
    .o_word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; i_start only matters when no load is running.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (i_start) next_state = LEN;
      end
      LEN: begin
        if (word_valid) begin
          if (packed_word == 32'd0)              next_state = DONE;
          else if (packed_word > MEM_DEPTH_32)   next_state = ERR;
          else                                   next_state = DATA;
        end
      end
      DATA: begin
        if (word_valid) next_state = WRITE;
      end
      WRITE: begin
        next_state = last_word ? DONE : DATA;
      end
      default: next_state = IDLE;
    endcase
  end

  // Status and handshake outputs decode directly from the state register.
  always_comb begin
    o_rx_ready = (state == LEN) || (state == DATA);
    o_busy     = (state == LEN) || (state == DATA) || (state == WRITE);
    o_done     = (state == DONE);
    o_err      = (state == ERR);
  end

  // Length capture, word addressing and the registered memory write port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len      <= '0;
      word_cnt <= '0;
      o_we     <= 1'b0;
      o_waddr  <= '0;
      o_wdata  <= '0;
    end else begin
      o_we <= (next_state == WRITE);
      if (start_ok) begin
        len      <= '0;
        word_cnt <= '0;
      end
      if ((state == LEN) && word_valid) begin
        len <= packed_word;
      end
      if ((state == DATA) && word_valid) begin
        o_waddr <= word_cnt[ADDR_WIDTH-1:0];
        o_wdata <= packed_word;
      end
      if (state == WRITE) begin
        word_cnt <= word_cnt + (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader, built with a 16-word memory.
module tb_imem_loader;

  localparam int AW = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int write_count = 0;
  int last_waddr = -1;
  exp_t sb[$];
  logic [31:0] img [0:15];

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_rx_ready (rx_ready),
    .o_we       (we),
    .o_waddr    (waddr),
    .o_wdata    (wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      write_count++;
      last_waddr = int'(waddr);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%08h, expected no write", waddr, wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("waddr", 32'(waddr), 32'(e.addr));
        checkOutput("wdata", wdata, e.data);
      end
      checkOutput("ready_during_write", 32'(rx_ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic took;
    int n;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      took = rx_ready;
      @(posedge clk);
      #1;
      if (took) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL byte_accept_timeout: byte 0x%02h never accepted, expected acceptance", b);
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] len_field, input int send_words, input int max_gap);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_done_clear", 32'(done), 32'd0);
    checkOutput("start_err_clear", 32'(err), 32'd0);
    if (len_field >= 32'd1 && len_field <= 32'd16) begin
      for (int i = 0; i < send_words && i < int'(len_field); i++) begin
        exp_t e;
        e.addr = AW'(i);
        e.data = img[i];
        sb.push_back(e);
      end
    end
    for (int b = 0; b < 4; b++)
      send_byte(len_field[8*b +: 8], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    for (int w = 0; w < send_words; w++) begin
      logic [31:0] word;
      word = img[w];
      for (int b = 0; b < 4; b++)
        send_byte(word[8*b +: 8], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done || err) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s_timeout: no done/err after 200 cycles, expected one", name);
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checkOutput({name, "_we"}, 32'(we), 32'd0);
    checkOutput({name, "_waddr"}, 32'(waddr), 32'd0);
    checkOutput({name, "_wdata"}, wdata, 32'd0);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_done"}, 32'(done), 32'd0);
    checkOutput({name, "_err"}, 32'(err), 32'd0);
    checkOutput({name, "_ready"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    int wc;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    $display("[TB] basic two-word load");
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    applyStimulus(32'd2, 2, 0);
    wait_end("basic");
    checkOutput("basic_done", 32'(done), 32'd1);
    checkOutput("basic_busy", 32'(busy), 32'd0);
    checkOutput("basic_writes", 32'(write_count), 32'd2);
    checkOutput("basic_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] restart from done, three words without gaps");
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h1234_5678;
    img[2] = 32'h0000_A5A5;
    wc = write_count;
    applyStimulus(32'd3, 3, 0);
    wait_end("nogap");
    checkOutput("nogap_done", 32'(done), 32'd1);
    checkOutput("nogap_writes", 32'(write_count - wc), 32'd3);

    $display("[TB] same three words with random gaps");
    wc = write_count;
    applyStimulus(32'd3, 3, 5);
    wait_end("gap");
    checkOutput("gap_done", 32'(done), 32'd1);
    checkOutput("gap_writes", 32'(write_count - wc), 32'd3);
    checkOutput("gap_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] zero-length image");
    wc = write_count;
    applyStimulus(32'd0, 0, 0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("zero_writes", 32'(write_count - wc), 32'd0);

    $display("[TB] oversize header");
    wc = write_count;
    applyStimulus(32'd17, 0, 0);
    wait_end("over");
    checkOutput("over_err", 32'(err), 32'd1);
    checkOutput("over_done", 32'(done), 32'd0);
    checkOutput("over_busy", 32'(busy), 32'd0);
    checkOutput("over_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("over_writes", 32'(write_count - wc), 32'd0);

    $display("[TB] full-depth image after error");
    for (int i = 0; i < 16; i++) img[i] = 32'h0101_0101 * i + 32'h0000_0013;
    wc = write_count;
    applyStimulus(32'd16, 16, 0);
    wait_end("full");
    checkOutput("full_done", 32'(done), 32'd1);
    checkOutput("full_err", 32'(err), 32'd0);
    checkOutput("full_writes", 32'(write_count - wc), 32'd16);
    checkOutput("full_last_addr", 32'(last_waddr), 32'd15);

    $display("[TB] reset in the middle of a load");
    img[0] = 32'hCAFE_0001;
    img[1] = 32'hCAFE_0002;
    img[2] = 32'hCAFE_0003;
    img[3] = 32'hCAFE_0004;
    wc = write_count;
    applyStimulus(32'd4, 2, 0);
    @(posedge clk);
    #2;
    checkOutput("midload_busy", 32'(busy), 32'd1);
    checkOutput("midload_writes", 32'(write_count - wc), 32'd2);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wc = write_count;
    applyStimulus(32'd4, 4, 0);
    wait_end("reload");
    checkOutput("reload_done", 32'(done), 32'd1);
    checkOutput("reload_writes", 32'(write_count - wc), 32'd4);
    checkOutput("reload_sb_empty", 32'(sb.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream (e.g. from a UART RX block) and writes it word-by-word into the instruction RAM the fetch stage reads.
- Holds the core in reset (o_busy) while loading.
- Pulses completion or error status when loading ends.
- Sits between the serial RX front-end and the write port of the instruction memory.

Parameters:
- DATA_WIDTH, 32, memory word width; fixed at 32 (4 bytes per word).
- ADDR_WIDTH, 12, word address width; MEM_DEPTH = 1 << ADDR_WIDTH words.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous, active-high reset
- i_start  input  1  arm loader; sampled only in IDLE, DONE, ERR
- i_rx_valid  input  1  byte stream valid
- i_rx_data  input  8  byte stream data
- o_rx_ready  output  1  loader accepts a byte this cycle
- o_we  output  1  memory write enable, one-cycle pulse per word
- o_waddr  output  ADDR_WIDTH  word address of the write
- o_wdata  output  DATA_WIDTH  write data
- o_busy  output  1  load in progress; drives the core reset
- o_done  output  1  level; image fully written
- o_err  output  1  level; header length exceeds MEM_DEPTH

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; byte counter, word counter, length and assembly registers cleared. Memory contents are not touched. A reset mid-load abandons the load; a partially written image stays in memory.
- Byte transfer occurs on a rising edge when i_rx_valid & o_rx_ready. o_rx_ready is a registered function of state: 1 only in LEN and DATA.
- Image format: 4-byte little-endian word count N, followed by N words. Each word is 4 bytes, little-endian (the first byte goes to bits [7:0]).
- States:
  - IDLE: i_start=1 -> LEN, o_busy=1.
  - LEN: collect 4 bytes into len[31:0]. After the 4th byte:
    - N==0 -> DONE
    - N > MEM_DEPTH (unsigned 32-bit compare) -> ERR
    - otherwise -> DATA
  - DATA: collect 4 bytes into the word register. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle. o_we=1, o_waddr=word counter, o_wdata=assembled word, o_rx_ready=0. Word counter increments. If word counter+1 == N -> DONE, else -> DATA.
  - DONE: o_done=1, o_busy=0. i_start=1 -> LEN (clears o_done, restarts at address 0).
  - ERR: o_err=1, o_busy=0, no writes issued. i_start=1 -> LEN (clears o_err).
- i_start is ignored in LEN, DATA and WRITE.
- Bytes presented while o_rx_ready=0 are not consumed; the upstream block holds them.
- Byte counter is 2 bits and wraps 3->0 on the 4th accepted byte. It resets to 0 when entering LEN.
- Word counter is ADDR_WIDTH+1 bits, so N == MEM_DEPTH is legal: last write goes to address MEM_DEPTH-1 and the counter never wraps the address.
- Throughput: 1 byte per cycle with a continuous stream. Each word costs 4 accept cycles plus 1 WRITE cycle.
- o_we, o_waddr and o_wdata are registered. Memory latches the write on the edge after o_we rises.
- o_busy is 1 in LEN, DATA and WRITE.

Decomposition:
- Shared package loader_pkg contains:
  - loader_state_e enum {IDLE, LEN, DATA, WRITE, DONE, ERR}
  - BYTES_PER_WORD = 4 localparam
- One sub-module is natural: byte_packer.
  - Holds the 2-bit byte counter and the little-endian shift/insert into a 32-bit register.
  - Outputs word_valid on the 4th byte.
  - Reused for both LEN and DATA phases; clear input driven by the FSM.

Test Plan:
- Basic load: i_start, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00, continuous valid -> two o_we pulses: addr 0 data 0x00000013, addr 1 data 0x00100093. o_done=1, o_busy=0 after the 2nd write. No o_rx_ready during WRITE cycles.
- Zero length: header 00 00 00 00 -> no o_we, o_done=1 one cycle after the 4th byte.
- Oversize: ADDR_WIDTH=4, header 11 00 00 00 (17 > 16) -> o_err=1, no writes. Re-issue i_start with header 10 00 00 00 plus 16 words -> writes to addr 0..15, last at 15, o_done=1.
- Backpressure/gaps: random i_rx_valid gaps of 0-5 cycles during a 3-word load -> identical write sequence and data as the gap-free run.
- Reset mid-load: assert i_rst after 2 of 4 words have been written -> all outputs 0 immediately (async). After release, a new i_start and a full image writes starting at addr 0.
- Restart from DONE: i_start while o_done=1 -> o_done clears next cycle, o_busy=1, new image overwrites from addr 0.
